data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's load/store port: accepts one word request
//  per handshake, applies writes with byte enables, returns read data or ack.

---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_responder_dmem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
// Defaults here are what the top uses unless a build overrides them.
package data_mem_responder_pkg;

    localparam int DMEM_DEPTH_LOG2 = 8;
    localparam int DMEM_LATENCY    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// No reset: contents survive a responder reset.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DMEM_DEPTH_LOG2
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Read output only moves on an enabled access, so it holds through the response.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side target for the CPU load/store port: one request per handshake,
// programmable wait states, byte-enabled stores, range/alignment error flag.
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | counting wait states after accept
// S_RESP | response held until resp_ready_i
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = DMEM_DEPTH_LOG2,
    parameter int          LATENCY    = DMEM_LATENCY,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [31:0]     SPAN     = 32'(4 * (2**DEPTH_LOG2));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             load_q, load_d;

    logic        accept;
    logic [31:0] offset;
    logic        req_err;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    // Unsigned subtract: addresses below the base wrap high and fail the range test.
    assign offset  = req_addr_i - BASE_ADDR;
    assign req_err = (req_addr_i[1:0] != 2'b00) || (offset >= SPAN);
    assign accept  = req_valid_i && req_ready_o;
    assign ram_we  = (req_write_i && !req_err) ? req_be_i : 4'b0000;

    dmem_array #(.ADDR_W(DEPTH_LOG2)) u_array (
        .clk_i   (clock_i),
        .en_i    (accept),
        .we_i    (ram_we),
        .addr_i  (offset[DEPTH_LOG2+1:2]),
        .wdata_i (req_wdata_i),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // The accept edge already counts as the first latency cycle, so WAIT starts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d  = req_err;
                    load_d = !req_write_i;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q >= CNT_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        req_ready_o  = reset_i && (state_q == S_IDLE);
        resp_valid_o = (state_q == S_RESP);
        resp_err_o   = resp_valid_o && err_q;
        resp_rdata_o = (resp_valid_o && load_q && !err_q) ? ram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model,
// plus a LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

    localparam int          LAT   = 2;
    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        reset1, req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;
    logic [3:0]  req_be1;

    data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT), .BASE_ADDR(BASE)) u_dut (
        .clock_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
        .clock_i(clk), .reset_i(reset1),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_write_i(req_write1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_be_i(req_be1),
        .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
        .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_m [WORDS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (off >= 32'(4 * WORDS));
    endfunction

    // Reference model: apply a store or fetch a load's expected data.
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] exp_d, output bit exp_e);
        int idx;
        exp_e = ref_err(addr);
        exp_d = 32'h0;
        if (!exp_e) begin
            idx = int'((addr - BASE) / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_d = mem_m[idx];
            end
        end
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int bp, input bit early,
                       output logic [31:0] got_rdata);
        logic [31:0] exp_d, h_d;
        bit          exp_e;
        logic        h_e;
        int          lat;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        chk("ready_idle", 32'(req_ready), 32'd1);
        model_access(wr, addr, wdata, be, exp_d, exp_e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        if (early) resp_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk("latency", 32'(lat), 32'(LAT));
        chk("rdata", resp_rdata, exp_d);
        chk("err", 32'(resp_err), 32'(exp_e));
        chk("ready_busy", 32'(req_ready), 32'd0);
        h_d = resp_rdata;
        h_e = resp_err;
        if (!early) begin
            for (int i = 0; i < bp; i++) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'b1;
                req_addr  = {22'd0, 8'($urandom), 2'b00};
                req_be    = 4'hF;
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, h_d);
                chk("hold_err", 32'(resp_err), 32'(h_e));
                chk("hold_ready", 32'(req_ready), 32'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_drop", 32'(resp_valid), 32'd0);
        got_rdata = h_d;
    endtask

    // Accept a request, then reset while in WAIT; no response may appear.
    task automatic reset_in_wait(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_d;
        bit          exp_e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = 4'hF;
        model_access(wr, addr, wdata, 4'hF, exp_d, exp_e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready_low", 32'(req_ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_after_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rst_after_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, addr;
        int          r;
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        reset1 = 1'b0; req_valid1 = 1'b0; resp_ready1 = 1'b0;
        req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_valid", 32'(resp_valid), 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_err", 32'(resp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < WORDS; i++)
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, 1'b0, d);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, d);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, d);
        chk("dir_load_full", d, 32'hDEAD_BEEF);
        txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, 1'b0, d);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, d);
        chk("dir_load_bytes", d, 32'hDE22_BE44);
        txn(1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, d);
        txn(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, d);
        txn(1'b1, 32'h0, 32'hCAFE_F00D, 4'h0, 0, 1'b0, d);
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, d);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b0, d);
        chk("dir_bp_load", d, 32'hDE22_BE44);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr = BASE + {22'd0, 8'($urandom), 2'b00};
            else if (r == 7) addr = BASE + {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 8) addr = BASE + 32'h400 + 32'($urandom_range(0, 255));
            else             addr = $urandom;
            txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom),
                int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), d);
        end

        reset_in_wait(1'b0, 32'h20, 32'h0);
        reset_in_wait(1'b1, 32'h24, 32'h5A5A_A5A5);
        txn(1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0, d);
        chk("committed_store", d, 32'h5A5A_A5A5);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 1, 1'b0, d);

        // LATENCY=1 instance: continuous misaligned loads, one response every 2 cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset1 = 1'b1;
        req_valid1 = 1'b1;
        req_addr1 = 32'h3;
        resp_ready1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("l1_valid", 32'(resp_valid1), 32'((i % 2) == 0));
            if (resp_valid1) begin
                chk("l1_err", 32'(resp_err1), 32'd1);
                chk("l1_rdata", resp_rdata1, 32'd0);
            end
        end
        req_valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
